// File: rtl/axis_level_fifo.sv
// First-word-fall-through stream FIFO that absorbs a source which never stalls.
// Storage is a block RAM with a registered read port, followed by an output register.
module axis_level_fifo #(
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int ADDR_WIDTH       = 10
) (
  input  logic                        aclk,
  input  logic                        aresetn,
  input  logic [AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic                        s_axis_tvalid,
  output logic                        s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
  output logic                        m_axis_tvalid,
  input  logic                        m_axis_tready,
  input  logic                        overflow_clear,
  output logic [ADDR_WIDTH:0]         read_count,
  output logic                        overflow
);

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] ONE      = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [AXIS_TDATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [AXIS_TDATA_WIDTH-1:0] ram_q;
  logic [ADDR_WIDTH:0]         wr_ptr;
  logic [ADDR_WIDTH:0]         rd_ptr;
  logic                        mid_valid;

  logic push;
  logic drop;
  logic pop;
  logic out_load;
  logic rd_en;

  assign s_axis_tready = 1'b1;

  // read_count covers RAM, the RAM read register and the output register,
  // so "full" here means every storage slot in the whole pipeline is occupied.
  assign push     = s_axis_tvalid && (read_count != CAPACITY);
  assign drop     = s_axis_tvalid && (read_count == CAPACITY);
  assign pop      = m_axis_tvalid && m_axis_tready;
  assign out_load = mid_valid && (!m_axis_tvalid || m_axis_tready);
  assign rd_en    = (wr_ptr != rd_ptr) && (!mid_valid || out_load);

  always_ff @(posedge aclk) begin
    if (aresetn && push)
      mem[wr_ptr[ADDR_WIDTH-1:0]] <= s_axis_tdata;
  end

  always_ff @(posedge aclk) begin
    if (rd_en)
      ram_q <= mem[rd_ptr[ADDR_WIDTH-1:0]];
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      mid_valid     <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      read_count    <= '0;
      overflow      <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + ONE;
      if (rd_en)
        rd_ptr <= rd_ptr + ONE;

      if (rd_en)
        mid_valid <= 1'b1;
      else if (out_load)
        mid_valid <= 1'b0;

      if (out_load) begin
        m_axis_tvalid <= 1'b1;
        m_axis_tdata  <= ram_q;
      end else if (pop) begin
        m_axis_tvalid <= 1'b0;
      end

      case ({push, pop})
        2'b10:   read_count <= read_count + ONE;
        2'b01:   read_count <= read_count - ONE;
        default: read_count <= read_count;
      endcase

      // A drop on the same edge as a clear must stay visible.
      if (drop)
        overflow <= 1'b1;
      else if (overflow_clear)
        overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axis_level_fifo.sv
// Self-checking bench for axis_level_fifo: a vector table, directed corner sequences,
// and random traffic compared against a queue-based reference model.
module tb_axis_level_fifo;

  localparam int DW  = 32;
  localparam int AW  = 4;
  localparam int CAP = 1 << AW;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [DW-1:0] s_axis_tdata = '0;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic          overflow_clear = 1'b0;
  logic [AW:0]   read_count;
  logic          overflow;

  axis_level_fifo #(.AXIS_TDATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .aclk           (aclk),
    .aresetn        (aresetn),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .overflow_clear (overflow_clear),
    .read_count     (read_count),
    .overflow       (overflow)
  );

  always #5 aclk = ~aclk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [DW-1:0] modelQ[$];
  int            modelT[$];
  bit            modelOvf = 1'b0;
  logic [DW-1:0] popLog[$];

  typedef struct {
    bit          rst;
    bit          tv;
    logic [31:0] td;
    bit          tr;
    bit          clr;
    int          expCount;
    bit          expOvf;
    bit          chkOut;
    bit          expValid;
    logic [31:0] expData;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model-level checks done after every edge.
  task automatic checkOutput();
    check("read_count", 64'(read_count), 64'(modelQ.size()));
    check("overflow", 64'(overflow), 64'(modelOvf));
    check("tready_const", 64'(s_axis_tready), 64'd1);
    if (m_axis_tvalid === 1'b1) begin
      check("valid_nonempty", 64'(modelQ.size() != 0), 64'd1);
      if (modelQ.size() != 0)
        check("head_data", 64'(m_axis_tdata), 64'(modelQ[0]));
    end else if (modelQ.size() != 0 && modelT[0] <= cyc - 2) begin
      check("fwft_latency", 64'(m_axis_tvalid), 64'd1);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit tv, input logic [31:0] td,
                               input bit tr, input bit clr);
    logic          vPre;
    logic [DW-1:0] dPre;
    bit            full;
    aresetn        = !rst;
    s_axis_tvalid  = tv;
    s_axis_tdata   = td;
    m_axis_tready  = tr;
    overflow_clear = clr;
    vPre = m_axis_tvalid;
    dPre = m_axis_tdata;
    @(posedge aclk);
    #1;
    cyc++;
    if (rst) begin
      modelQ.delete();
      modelT.delete();
      modelOvf = 1'b0;
    end else begin
      full = (modelQ.size() == CAP);
      if (vPre === 1'b1 && tr && modelQ.size() > 0) begin
        popLog.push_back(dPre);
        void'(modelQ.pop_front());
        void'(modelT.pop_front());
      end
      if (tv && full)
        modelOvf = 1'b1;
      else if (clr)
        modelOvf = 1'b0;
      if (tv && !full) begin
        modelQ.push_back(td);
        modelT.push_back(cyc);
      end
    end
    checkOutput();
  endtask

  task automatic pushWords(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b1, base + 32'(i), 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && modelQ.size() != 0; i++)
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("drain_timeout", 64'(modelQ.size()), 64'd0);
  endtask

  vec_t vecs[16];

  initial begin
    logic [31:0] expSeq[$];
    int pTv;
    int pTr;

    vecs[0]  = '{1, 0, 32'h0,  0, 0, 0, 0, 1, 0, 32'h0};
    vecs[1]  = '{0, 1, 32'h11, 0, 0, 1, 0, 0, 0, 32'h0};
    vecs[2]  = '{0, 0, 32'h0,  0, 0, 1, 0, 0, 0, 32'h0};
    vecs[3]  = '{0, 0, 32'h0,  0, 0, 1, 0, 1, 1, 32'h11};
    vecs[4]  = '{0, 0, 32'h0,  1, 0, 0, 0, 1, 0, 32'h0};
    vecs[5]  = '{0, 0, 32'h0,  1, 0, 0, 0, 1, 0, 32'h0};
    vecs[6]  = '{0, 1, 32'hA1, 0, 0, 1, 0, 0, 0, 32'h0};
    vecs[7]  = '{0, 1, 32'hA2, 0, 0, 2, 0, 0, 0, 32'h0};
    vecs[8]  = '{0, 1, 32'hA3, 0, 0, 3, 0, 1, 1, 32'hA1};
    vecs[9]  = '{0, 0, 32'h0,  0, 0, 3, 0, 1, 1, 32'hA1};
    vecs[10] = '{0, 0, 32'h0,  1, 0, 2, 0, 1, 1, 32'hA2};
    vecs[11] = '{0, 1, 32'hA4, 1, 0, 2, 0, 1, 1, 32'hA3};
    vecs[12] = '{0, 0, 32'h0,  1, 0, 1, 0, 0, 0, 32'h0};
    vecs[13] = '{0, 0, 32'h0,  0, 0, 1, 0, 1, 1, 32'hA4};
    vecs[14] = '{0, 0, 32'h0,  1, 0, 0, 0, 1, 0, 32'h0};
    vecs[15] = '{0, 0, 32'h0,  0, 1, 0, 0, 0, 0, 32'h0};

    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].tv, vecs[i].td, vecs[i].tr, vecs[i].clr);
      check($sformatf("vec%0d_count", i), 64'(read_count), 64'(vecs[i].expCount));
      check($sformatf("vec%0d_ovf", i), 64'(overflow), 64'(vecs[i].expOvf));
      if (vecs[i].chkOut) begin
        check($sformatf("vec%0d_valid", i), 64'(m_axis_tvalid), 64'(vecs[i].expValid));
        if (vecs[i].expValid || vecs[i].rst)
          check($sformatf("vec%0d_data", i), 64'(m_axis_tdata), 64'(vecs[i].expData));
      end
    end

    // Order across the pointer wrap point.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    popLog.delete();
    pushWords(32'd0, 16);
    check("wrap_full_count", 64'(read_count), 64'd16);
    idle(2);
    for (int i = 0; i < 10; i++)
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    pushWords(32'd100, 10);
    check("wrap_refill_count", 64'(read_count), 64'd16);
    drain(60);
    expSeq.delete();
    for (int i = 0; i < 16; i++) expSeq.push_back(32'(i));
    for (int i = 0; i < 10; i++) expSeq.push_back(32'(100 + i));
    check("wrap_log_len", 64'(popLog.size()), 64'(expSeq.size()));
    for (int i = 0; i < expSeq.size() && i < popLog.size(); i++)
      check($sformatf("wrap_order%0d", i), 64'(popLog[i]), 64'(expSeq[i]));

    // Overflow, clear, then push+pop while full.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    popLog.delete();
    pushWords(32'd0, 16);
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b0);
    check("ovf_count", 64'(read_count), 64'd16);
    check("ovf_set", 64'(overflow), 64'd1);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    check("ovf_cleared", 64'(overflow), 64'd0);
    applyStimulus(1'b0, 1'b1, 32'hBEEF, 1'b1, 1'b0);
    check("fullpp_count", 64'(read_count), 64'd15);
    check("fullpp_ovf", 64'(overflow), 64'd1);
    drain(40);
    check("ovf_log_len", 64'(popLog.size()), 64'd16);
    for (int i = 0; i < 16 && i < popLog.size(); i++)
      check($sformatf("ovf_order%0d", i), 64'(popLog[i]), 64'(i));

    // Sustained one-per-cycle throughput.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    popLog.delete();
    pushWords(32'd1000, 8);
    idle(3);
    for (int i = 0; i < 200; i++) begin
      check("tput_no_bubble", 64'(m_axis_tvalid), 64'd1);
      applyStimulus(1'b0, 1'b1, 32'(1008 + i), 1'b1, 1'b0);
      check("tput_count", 64'(read_count), 64'd8);
    end
    check("tput_log_len", 64'(popLog.size()), 64'd200);
    for (int i = 0; i < 200 && i < popLog.size(); i++)
      check("tput_contig", 64'(popLog[i]), 64'(1000 + i));

    // Reset in the middle of traffic.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    pushWords(32'h200, 16);
    applyStimulus(1'b0, 1'b1, 32'hDEAD, 1'b0, 1'b0);
    idle(2);
    for (int i = 0; i < 7; i++)
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("mid_pre_count", 64'(read_count), 64'd9);
    check("mid_pre_ovf", 64'(overflow), 64'd1);
    applyStimulus(1'b1, 1'b1, 32'h77, 1'b1, 1'b0);
    check("mid_rst_count", 64'(read_count), 64'd0);
    check("mid_rst_valid", 64'(m_axis_tvalid), 64'd0);
    check("mid_rst_ovf", 64'(overflow), 64'd0);
    popLog.delete();
    applyStimulus(1'b0, 1'b1, 32'h55, 1'b0, 1'b0);
    idle(2);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    check("mid_first_len", 64'(popLog.size()), 64'd1);
    if (popLog.size() > 0)
      check("mid_first_word", 64'(popLog[0]), 64'h55);

    // Random traffic with shifting push/pop pressure.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    pTv = 60;
    pTr = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 300 == 0) begin
        pTv = int'($urandom_range(10, 95));
        pTr = int'($urandom_range(10, 95));
      end
      applyStimulus($urandom_range(0, 199) == 0,
                    $urandom_range(0, 99) < pTv,
                    $urandom,
                    $urandom_range(0, 99) < pTr,
                    $urandom_range(0, 19) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axis_level_fifo.md
Name: axis_level_fifo

Overview:
- Synchronous stream FIFO placed directly upstream of the AXI4-Lite stream reader.
- Absorbs a free-running AXI-Stream source, such as ADC or decimator output, that ignores backpressure.
- Presents words to the reader in first-word-fall-through form.
- Exports a fill level and a sticky overflow flag, so software can poll the level before issuing reads and can detect lost samples.

Parameters:
AXIS_TDATA_WIDTH, 32, stream data width in bits; must equal the reader's AXI_DATA_WIDTH.
ADDR_WIDTH, 10, log2 of capacity; CAPACITY = 2^ADDR_WIDTH words, counting every stored word including the output register.

Ports:
aclk  in  1  clock
aresetn  in  1  synchronous active-low reset
s_axis_tdata  in  AXIS_TDATA_WIDTH  input stream data
s_axis_tvalid  in  1  input stream valid
s_axis_tready  out  1  tied 1; source is never stalled
m_axis_tdata  out  AXIS_TDATA_WIDTH  output data; registered
m_axis_tvalid  out  1  output valid; registered
m_axis_tready  in  1  pop request from downstream reader
overflow_clear  in  1  single-cycle pulse; clears the overflow flag
read_count  out  ADDR_WIDTH+1  number of words currently held, 0..CAPACITY; registered
overflow  out  1  sticky: at least one input word was dropped; registered

Behaviour:
- Reset is synchronous on aresetn low and applies mid-operation. All contents are discarded.
  - read_count = 0, m_axis_tvalid = 0, m_axis_tdata = 0, overflow = 0, all pointers = 0.
  - A handshake presented during the reset cycle is ignored.
- Push: a word is accepted on any edge where s_axis_tvalid = 1 and read_count < CAPACITY.
- Full drop: if s_axis_tvalid = 1 and read_count == CAPACITY at the edge, the word is discarded and overflow is set.
  - Full is judged on the registered read_count, so a pop on the same edge does not rescue the incoming word.
- Pop: occurs on an edge where m_axis_tvalid = 1 and m_axis_tready = 1.
  - The word at the head leaves the FIFO.
  - m_axis_tdata and m_axis_tvalid must not change while m_axis_tvalid = 1 and m_axis_tready = 0.
- read_count update at each edge: +1 on push only; -1 on pop only; unchanged on push plus pop together or on neither.
  - read_count never wraps; it saturates by construction because pushes are refused at CAPACITY.
- Order is strict FIFO and no word is duplicated.
  - Pointers wrap modulo CAPACITY, across the wrap point included.
- Latency:
  - Word pushed into an empty FIFO at edge k: m_axis_tvalid = 1 with that data after edge k+2 at the latest.
  - read_count reflects the push after edge k itself.
- Throughput: with ≥3 words held and m_axis_tready held at 1, one word pops per cycle with no bubbles.
  - Any internal prefetch stage must be accounted for in the CAPACITY and read_count figures.
- Empty pop: m_axis_tready = 1 while m_axis_tvalid = 0 has no effect.
  - The downstream reader then returns 0 to software on its own.
- Overflow flag:
  - overflow_clear = 1 clears overflow at the next edge.
  - If a drop occurs on the same edge as a clear, the set wins and overflow stays 1.
  - A drop is never masked by a clear.
- Storage: inferred block RAM with a registered read port; no asynchronous-read memory.
- No output depends combinationally on any input except s_axis_tready, which is a constant.

Test Plan:
- Reset and single word: release reset, push 0x00000011 once with m_axis_tready = 0. read_count = 1 after that edge; m_axis_tvalid = 1 with tdata = 0x00000011 within 2 cycles. Assert tready for 1 cycle: read_count = 0, tvalid = 0.
- Order and wrap (ADDR_WIDTH = 4): push 0..15 continuously with tready = 0; read_count = 16. Pop 10 words. Push 100..109. Pop all 16 remaining words: sequence 10..15, 100..109 exactly, no gaps or duplicates.
- Overflow (ADDR_WIDTH = 4): fill to 16, push 0xDEAD for 3 more cycles. read_count stays 16, overflow = 1, 0xDEAD is never output. Pulse overflow_clear: overflow = 0 next cycle.
- Full with simultaneous push and pop: at read_count = 16, drive push and pop on the same edge. Head word leaves, pushed word is dropped, read_count = 15, overflow = 1.
- Throughput: preload 8 words, then push and pop every cycle for 200 cycles with incrementing data. tvalid stays 1 throughout, one word pops per cycle, read_count constant at 8, output sequence is contiguous.
- Reset mid-operation: with 9 words held and overflow = 1, assert aresetn = 0 for 1 cycle. Next cycle: read_count = 0, tvalid = 0, overflow = 0. A new push of 0x55 is the first word output.
